// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - opcodes, format codes, buffer states and entry type for imm_target_gen
package imm_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_OPIMM   = 7'b0010011;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OP_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_OP      = 7'b0110011;
  localparam logic [6:0] OP_OP32    = 7'b0111011;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

  // Fields sized for the widest datapath; narrower instances use the low XLEN bits.
  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [XLEN_MAX-1:0] imm;
    logic [XLEN_MAX-1:0] target;
    fmt_t                fmt;
    logic                illegal;
  } entry_t;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational opcode classification, immediate and target generation
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RV64_OPS = 1
) (
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output entry_t          o_entry
);

  localparam bit RV64_EN = (XLEN == 64) && (RV64_OPS != 0);

  logic [6:0]      w_opcode;
  fmt_t            w_fmt;
  logic            w_pcrel;
  logic [63:0]     w_imm64;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_target;
  logic            w_unused;

  assign w_opcode = i_instr[6:0];

  always_comb begin
    w_fmt   = FMT_ILL;
    w_pcrel = 1'b0;
    case (w_opcode)
      OP_LOAD, OP_OPIMM, OP_JALR, OP_SYSTEM: w_fmt = FMT_I;
      OP_OPIMM32: if (RV64_EN) w_fmt = FMT_I;
      OP_STORE:   w_fmt = FMT_S;
      OP_BRANCH:  begin w_fmt = FMT_B; w_pcrel = 1'b1; end
      OP_LUI:     w_fmt = FMT_U;
      OP_AUIPC:   begin w_fmt = FMT_U; w_pcrel = 1'b1; end
      OP_JAL:     begin w_fmt = FMT_J; w_pcrel = 1'b1; end
      OP_OP:      w_fmt = FMT_R;
      OP_OP32:    if (RV64_EN) w_fmt = FMT_R;
      default:    ;
    endcase
  end

  // Built at 64 bits and truncated, so U-type sign extension falls out for RV64.
  always_comb begin
    w_imm64 = '0;
    case (w_fmt)
      FMT_I:   w_imm64 = {{52{i_instr[31]}}, i_instr[31:20]};
      FMT_S:   w_imm64 = {{52{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      FMT_B:   w_imm64 = {{51{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                          i_instr[11:8], 1'b0};
      FMT_U:   w_imm64 = {{32{i_instr[31]}}, i_instr[31:12], 12'b0};
      FMT_J:   w_imm64 = {{43{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                          i_instr[30:21], 1'b0};
      default: w_imm64 = '0;
    endcase
  end

  assign w_imm    = w_imm64[XLEN-1:0];
  assign w_target = i_pc + (w_pcrel ? w_imm : XLEN'(4));
  assign w_unused = ^w_imm64;

  always_comb begin
    o_entry                    = '0;
    o_entry.pc[XLEN-1:0]       = i_pc;
    o_entry.imm[XLEN-1:0]      = w_imm;
    o_entry.target[XLEN-1:0]   = w_target;
    o_entry.fmt                = w_fmt;
    o_entry.illegal            = (w_fmt == FMT_ILL);
  end

endmodule

// File: rtl/imm_target_gen.sv
// rtl/imm_target_gen.sv - decode stage immediate/target generator behind a 2-entry skid buffer
module imm_target_gen
  import imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RV64_OPS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  entry_t     w_dec;
  entry_t     r_m;
  entry_t     r_k;
  buf_state_t r_state;
  logic       r_in_ready;
  logic       r_out_valid;
  logic       w_accept;
  logic       w_unused;

  imm_decode #(
    .XLEN     (XLEN),
    .RV64_OPS (RV64_OPS)
  ) u_decode (
    .i_instr (in_instr),
    .i_pc    (in_pc),
    .o_entry (w_dec)
  );

  assign w_accept = in_valid && r_in_ready;

  // in_ready and out_valid are updated alongside the state so neither depends on out_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_m         <= '0;
      r_k         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_m         <= w_dec;
            r_state     <= ST_ONE;
            r_out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && out_ready) begin
            r_m <= w_dec;
          end else if (w_accept) begin
            r_k        <= w_dec;
            r_state    <= ST_TWO;
            r_in_ready <= 1'b0;
          end else if (out_ready) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        ST_TWO: begin
          if (out_ready) begin
            r_m        <= r_k;
            r_state    <= ST_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_imm     = r_m.imm[XLEN-1:0];
  assign out_target  = r_m.target[XLEN-1:0];
  assign out_pc      = r_m.pc[XLEN-1:0];
  assign out_fmt     = r_m.fmt;
  assign out_illegal = r_m.illegal;
  assign w_unused    = ^r_m;

endmodule

// File: tb/tb_imm_target_gen.sv
// tb/tb_imm_target_gen.sv - bench for imm_target_gen driving an RV32 and an RV64 instance in lockstep
module tb_imm_target_gen;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_imm, a_out_target, a_out_pc;
  logic [2:0]  a_out_fmt;
  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [63:0] b_out_imm, b_out_target, b_out_pc;
  logic [2:0]  b_out_fmt;

  always #5 clk = ~clk;

  imm_target_gen #(.XLEN(32), .RV64_OPS(1)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_out_imm),
    .out_target(a_out_target), .out_pc(a_out_pc), .out_fmt(a_out_fmt), .out_illegal(a_out_illegal)
  );

  imm_target_gen #(.XLEN(64), .RV64_OPS(1)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_imm(b_out_imm),
    .out_target(b_out_target), .out_pc(b_out_pc), .out_fmt(b_out_fmt), .out_illegal(b_out_illegal)
  );

  typedef struct {
    logic [2:0]  fmt32;
    logic        ill32;
    logic [63:0] imm32, tgt32, pc32;
    logic [2:0]  fmt64;
    logic        ill64;
    logic [63:0] imm64, tgt64, pc64;
  } exp_t;

  exp_t        mq[$];
  logic [63:0] hs_q[$];
  int          total = 0;
  int          bad   = 0;

  wire [299:0] w_act = {a_out_valid, a_in_ready, a_out_fmt, a_out_illegal, a_out_imm, a_out_target,
                        a_out_pc, b_out_valid, b_in_ready, b_out_fmt, b_out_illegal, b_out_imm,
                        b_out_target, b_out_pc};

  function automatic void ref_decode(input logic [31:0] ins, input logic [63:0] pc, input bit is64,
                                     output logic [2:0] fmt, output logic ill,
                                     output logic [63:0] imm, output logic [63:0] tgt,
                                     output logic [63:0] pco);
    longint      v   = 0;
    bit          rel = 0;
    logic [63:0] msk = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    fmt = 3'd7;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: begin fmt = 3'd1; v = longint'($signed(ins[31:20])); end
      7'h1B: if (is64) begin fmt = 3'd1; v = longint'($signed(ins[31:20])); end
      7'h23: begin fmt = 3'd2; v = longint'($signed({ins[31:25], ins[11:7]})); end
      7'h63: begin
        fmt = 3'd3; rel = 1;
        v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      end
      7'h37: begin fmt = 3'd4; v = longint'($signed({ins[31:12], 12'h000})); end
      7'h17: begin fmt = 3'd4; rel = 1; v = longint'($signed({ins[31:12], 12'h000})); end
      7'h6F: begin
        fmt = 3'd5; rel = 1;
        v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      end
      7'h33: fmt = 3'd0;
      7'h3B: if (is64) fmt = 3'd0;
      default: ;
    endcase
    ill = (fmt == 3'd7);
    imm = 64'(v) & msk;
    tgt = (rel ? pc + 64'(v) : pc + 64'd4) & msk;
    pco = pc & msk;
  endfunction

  function automatic void model_step();
    if (!rst_n || flush) begin
      mq.delete();
    end else begin
      bit acc = in_valid && (mq.size() < 2);
      if (mq.size() > 0 && out_ready) mq.delete(0);
      if (acc) begin
        exp_t e;
        ref_decode(in_instr, in_pc, 1'b0, e.fmt32, e.ill32, e.imm32, e.tgt32, e.pc32);
        ref_decode(in_instr, in_pc, 1'b1, e.fmt64, e.ill64, e.imm64, e.tgt64, e.pc64);
        mq.push_back(e);
      end
    end
  endfunction

  function automatic logic [299:0] exp_vec();
    bit   v = (mq.size() > 0);
    bit   r = (mq.size() < 2);
    exp_t e = '{default: 0};
    if (v) e = mq[0];
    return {v, r, e.fmt32, e.ill32, e.imm32[31:0], e.tgt32[31:0], e.pc32[31:0],
            v, r, e.fmt64, e.ill64, e.imm64, e.tgt64, e.pc64};
  endfunction

  function automatic logic [299:0] mask_vec();
    if (mq.size() > 0) return '1;
    return {2'b11, 100'b0, 2'b11, 196'b0};
  endfunction

  task automatic tick();
    if (rst_n && !flush && a_out_valid && out_ready) hs_q.push_back({32'h0, a_out_pc});
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0; in_pc = '0;
    tick(); tick();
    rst_n = 1'b1;
    total++;
    if ({a_out_valid, a_out_fmt, a_out_illegal, a_out_imm, a_out_target, a_out_pc,
         b_out_valid, b_out_fmt, b_out_illegal, b_out_imm, b_out_target, b_out_pc} !== '0) begin
      bad++;
      $display("FAIL reset_outputs act=%h exp=0", w_act);
    end
    total++;
    if ({a_in_ready, b_in_ready} !== 2'b11) begin
      bad++;
      $display("FAIL reset_in_ready act=%b exp=11", {a_in_ready, b_in_ready});
    end
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [63:0] pc;
    bit          w64;
    logic [2:0]  fmt;
    logic        ill;
    logic [63:0] imm, tgt;
  } dir_t;

  task automatic test_directed();
    dir_t         tbl [0:6];
    logic [131:0] act, exp;
    tbl[0] = '{32'hFE000EE3, 64'h100,      0, 3'd3, 1'b0, 64'hFFFFFFFC, 64'hFC};
    tbl[1] = '{32'h001000EF, 64'h80000000, 0, 3'd5, 1'b0, 64'h800, 64'h80000800};
    tbl[2] = '{32'h001000EF, 64'hFFFFF900, 0, 3'd5, 1'b0, 64'h800, 64'h100};
    tbl[3] = '{32'h800002B7, 64'h1000,     1, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 64'h1004};
    tbl[4] = '{32'h0000007F, 64'h2000,     0, 3'd7, 1'b1, 64'h0, 64'h2004};
    tbl[5] = '{32'hFFF0029B, 64'h3000,     1, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h3004};
    tbl[6] = '{32'hFFF0029B, 64'h3000,     0, 3'd7, 1'b1, 64'h0, 64'h3004};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_instr = tbl[i].ins; in_pc = tbl[i].pc;
      tick();
      in_valid = 1'b0;
      total++;
      if ((w_act & mask_vec()) !== (exp_vec() & mask_vec()) || !a_out_valid) begin
        bad++;
        $display("FAIL directed_model[%0d] act=%h exp=%h", i, w_act, exp_vec());
      end
      if (tbl[i].w64) act = {b_out_fmt, b_out_illegal, b_out_imm, b_out_target};
      else act = {a_out_fmt, a_out_illegal, 32'h0, a_out_imm, 32'h0, a_out_target};
      exp = {tbl[i].fmt, tbl[i].ill, tbl[i].imm, tbl[i].tgt};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL directed_value[%0d] act=%h exp=%h", i, act, exp);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ins [0:2];
    logic [63:0] pcs [0:2];
    ins[0] = 32'h00500093; ins[1] = 32'hFE000EE3; ins[2] = 32'h001000EF;
    pcs[0] = 64'h400; pcs[1] = 64'h404; pcs[2] = 64'h408;
    hs_q.delete();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = ins[i]; in_pc = pcs[i];
      tick();
      total++;
      if ((w_act & mask_vec()) !== (exp_vec() & mask_vec())) begin
        bad++;
        $display("FAIL bp_stall[%0d] act=%h exp=%h", i, w_act, exp_vec());
      end
    end
    total++;
    if ({a_in_ready, b_in_ready} !== 2'b00) begin
      bad++;
      $display("FAIL bp_in_ready act=%b exp=00", {a_in_ready, b_in_ready});
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) in_valid = 1'b0;
      tick();
      total++;
      if ((w_act & mask_vec()) !== (exp_vec() & mask_vec())) begin
        bad++;
        $display("FAIL bp_drain[%0d] act=%h exp=%h", i, w_act, exp_vec());
      end
    end
    total++;
    if (hs_q.size() != 3 || hs_q[0] !== pcs[0] || hs_q[1] !== pcs[1] || hs_q[2] !== pcs[2]) begin
      bad++;
      $display("FAIL bp_order act_n=%0d exp_n=3 first=%h exp_first=%h", hs_q.size(),
               (hs_q.size() > 0) ? hs_q[0] : 64'h0, pcs[0]);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h00100113; in_pc = 64'h500; tick();
    in_instr = 32'h00200193; in_pc = 64'h504; tick();
    flush = 1'b1; in_instr = 32'h00300213; in_pc = 64'h508;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++;
    if ({a_out_valid, a_in_ready, b_out_valid, b_in_ready} !== 4'b0101) begin
      bad++;
      $display("FAIL flush_state act=%b exp=0101", {a_out_valid, a_in_ready, b_out_valid, b_in_ready});
    end
    hs_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ((w_act & mask_vec()) !== (exp_vec() & mask_vec())) begin
        bad++;
        $display("FAIL flush_after[%0d] act=%h exp=%h", i, w_act, exp_vec());
      end
    end
    total++;
    if (hs_q.size() != 0) begin
      bad++;
      $display("FAIL flush_emitted act=%0d exp=0", hs_q.size());
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [0:13];
    ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
            7'h33, 7'h3B, 7'h7F, 7'h0B};
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      in_instr  = $urandom;
      if ($urandom_range(0, 7) != 0) in_instr[6:0] = ops[$urandom_range(0, 13)];
      in_pc     = {$urandom, $urandom};
      tick();
      total++;
      if ((w_act & mask_vec()) !== (exp_vec() & mask_vec())) begin
        bad++;
        $display("FAIL random[%0d] act=%h exp=%h", i, w_act, exp_vec());
      end
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h800002B7; in_pc = 64'hFFFF_0000_1234_5678;
    tick();
    total++;
    if ((w_act & mask_vec()) !== (exp_vec() & mask_vec()) || !a_out_valid) begin
      bad++;
      $display("FAIL rst_pre act=%h exp=%h", w_act, exp_vec());
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    total++;
    if ({a_out_valid, a_out_fmt, a_out_illegal, a_out_imm, a_out_target, a_out_pc,
         b_out_valid, b_out_fmt, b_out_illegal, b_out_imm, b_out_target, b_out_pc} !== '0 ||
        {a_in_ready, b_in_ready} !== 2'b11) begin
      bad++;
      $display("FAIL rst_mid act=%h exp=ready_only", w_act);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
